// File: rtl/pulse_burst_sequencer.sv
// Programmable duty-window sequencer gating the two shifter pulse sources onto
// the analog pins, with a small register port and shadowed timing registers.
module pulse_burst_sequencer #(
    parameter int CW         = 16,
    parameter int PERIOD_RST = 100,
    parameter int HIGH_RST   = 30
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          cfg_we_i,
    input  logic [1:0]    cfg_addr_i,
    input  logic [CW-1:0] cfg_wdata_i,
    output logic [CW-1:0] cfg_rdata_o,
    input  logic [1:0]    pulse_in_i,
    output logic [1:0]    pulse_out_o,
    output logic          gate_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam logic [1:0] A_PERIOD = 2'd0;
    localparam logic [1:0] A_HIGH   = 2'd1;
    localparam logic [1:0] A_BURST  = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CW-1:0] r_period_sh;
    logic [CW-1:0] r_high_sh;
    logic [CW-1:0] r_burst_sh;
    logic [CW-1:0] r_period;
    logic [CW-1:0] r_high;
    logic [CW-1:0] r_burst;
    logic [1:0]    r_en;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_pcount;
    logic          r_gate;
    logic          r_err;
    logic [1:0]    r_pulse_out;

    logic          w_wr_ctrl;
    logic          w_start;
    logic          w_stop;
    logic          w_clr_err;
    logic          w_last;
    logic          w_burst_hit;
    logic [CW-1:0] w_pcount_inc;
    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] w_pcount_next;
    logic [CW-1:0] w_high_next;
    logic          w_load;
    logic          w_err_set;
    logic          w_gate_next;
    logic [CW-1:0] w_status;

    // STOP outranks START when both bits arrive in the same CTRL write.
    assign w_wr_ctrl = cfg_we_i && (cfg_addr_i == A_CTRL);
    assign w_start   = w_wr_ctrl && cfg_wdata_i[2] && !cfg_wdata_i[3];
    assign w_stop    = w_wr_ctrl && cfg_wdata_i[3];
    assign w_clr_err = w_wr_ctrl && cfg_wdata_i[4];

    assign w_last       = (r_cnt == r_period - CW'(1));
    assign w_pcount_inc = (&r_pcount) ? r_pcount : r_pcount + CW'(1);
    assign w_burst_hit  = (r_burst != '0) &&
                          (({1'b0, r_pcount} + (CW+1)'(1)) == {1'b0, r_burst});

    // Shadow registers and per-channel enables
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_period_sh <= CW'(PERIOD_RST);
            r_high_sh   <= CW'(HIGH_RST);
            r_burst_sh  <= '0;
            r_en        <= 2'b11;
        end else if (cfg_we_i) begin
            case (cfg_addr_i)
                A_PERIOD: r_period_sh <= cfg_wdata_i;
                A_HIGH:   r_high_sh   <= cfg_wdata_i;
                A_BURST:  r_burst_sh  <= cfg_wdata_i;
                default:  r_en        <= cfg_wdata_i[1:0];
            endcase
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_pcount_next = r_pcount;
        w_load        = 1'b0;
        w_err_set     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (r_period_sh == '0) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_load        = 1'b1;
                        w_cnt_next    = '0;
                        w_pcount_next = '0;
                        w_state_next  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_stop) begin
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end else if (w_last) begin
                    w_pcount_next = w_pcount_inc;
                    w_cnt_next    = '0;
                    if (w_burst_hit) begin
                        w_state_next = S_DONE;
                    end else begin
                        // Period boundary: pick up any mid-burst shadow changes.
                        w_load = 1'b1;
                        if (r_period_sh == '0) begin
                            w_err_set    = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Gate is computed from next-cycle values so the register lines up with r_cnt.
    assign w_high_next = w_load ? r_high_sh : r_high;
    assign w_gate_next = (w_state_next == S_RUN) && (w_cnt_next < w_high_next);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_pcount <= '0;
            r_gate   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_pcount <= w_pcount_next;
            r_gate   <= w_gate_next;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_period <= CW'(PERIOD_RST);
            r_high   <= CW'(HIGH_RST);
            r_burst  <= '0;
        end else if (w_load) begin
            r_period <= r_period_sh;
            r_high   <= r_high_sh;
            r_burst  <= r_burst_sh;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (w_clr_err) begin
            r_err <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
                if (!wb_rst_ni) begin
                    r_pulse_out[gi] <= 1'b0;
                end else begin
                    r_pulse_out[gi] <= r_gate & r_en[gi] & pulse_in_i[gi];
                end
            end
        end
    endgenerate

    // Status word layout assumes CW is at least 16.
    always_comb begin
        w_status        = '0;
        w_status[1:0]   = r_en;
        w_status[2]     = (r_state != S_IDLE);
        w_status[3]     = r_err;
        w_status[15:8]  = r_pcount[7:0];
    end

    always_comb begin
        case (cfg_addr_i)
            A_PERIOD: cfg_rdata_o = r_period_sh;
            A_HIGH:   cfg_rdata_o = r_high_sh;
            A_BURST:  cfg_rdata_o = r_burst_sh;
            default:  cfg_rdata_o = w_status;
        endcase
    end

    assign pulse_out_o = r_pulse_out;
    assign gate_o      = r_gate;
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = (r_state == S_DONE);
    assign err_o       = r_err;

endmodule

// File: tb/tb_pulse_burst_sequencer.sv
// Scoreboard bench: a window-schedule reference model queues the expected
// outputs for every clock; a monitor pops and compares on each falling edge.
module tb_pulse_burst_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic [1:0]  pulse_in;
    logic [1:0]  pulse_out;
    logic        gate, busy, done, err;

    pulse_burst_sequencer #(.CW(16), .PERIOD_RST(100), .HIGH_RST(30)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .cfg_rdata_o (cfg_rdata),
        .pulse_in_i  (pulse_in),
        .pulse_out_o (pulse_out),
        .gate_o      (gate),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        gate;
        logic [1:0]  pulse;
        logic        busy;
        logic        done;
        logic        err;
        logic        rd_v;
        logic [15:0] rd;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   pulse_rand = 1'b0;
    bit   rd_req = 1'b0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model: mode 0=idle 1=running 2=burst finished.
    // A window starting at cycle ws has position (cycle - ws); gate = position < high.
    int     m_mode = 0;
    int     m_sh_p = 100, m_sh_h = 30, m_sh_b = 0;
    int     m_p = 100, m_h = 30, m_b = 0;
    int     m_en = 3, m_err = 0, m_done_cnt = 0;
    longint m_cyc = 0, m_ws = 0;
    bit     m_gate = 1'b0;

    task automatic model_step();
        exp_t e;
        int   pulse_new;
        bit   start, stop, clr, errset;
        int   old;
        m_cyc++;
        pulse_new = 0;
        if (!rst_n) begin
            m_mode = 0; m_sh_p = 100; m_sh_h = 30; m_sh_b = 0;
            m_p = 100; m_h = 30; m_b = 0; m_en = 3; m_err = 0; m_done_cnt = 0;
        end else begin
            pulse_new = (m_gate ? m_en : 0) & int'(pulse_in);
            start  = cfg_we && cfg_addr == 2'd3 && cfg_wdata[2];
            stop   = cfg_we && cfg_addr == 2'd3 && cfg_wdata[3];
            clr    = cfg_we && cfg_addr == 2'd3 && cfg_wdata[4];
            errset = 1'b0;
            case (m_mode)
                2: m_mode = 0;
                1: begin
                    if (stop) begin
                        m_mode = 0;
                    end else if (m_cyc - 1 - m_ws == longint'(m_p - 1)) begin
                        old = m_done_cnt;
                        if (m_done_cnt < 65535) m_done_cnt++;
                        if (m_b != 0 && old + 1 == m_b) begin
                            m_mode = 2;
                        end else begin
                            m_p = m_sh_p; m_h = m_sh_h; m_b = m_sh_b; m_ws = m_cyc;
                            if (m_p == 0) begin
                                errset = 1'b1; m_mode = 0;
                            end
                        end
                    end
                end
                default: begin
                    if (start && !stop) begin
                        if (m_sh_p == 0) begin
                            errset = 1'b1;
                        end else begin
                            m_p = m_sh_p; m_h = m_sh_h; m_b = m_sh_b;
                            m_done_cnt = 0; m_ws = m_cyc; m_mode = 1;
                        end
                    end
                end
            endcase
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0: m_sh_p = int'(cfg_wdata);
                    2'd1: m_sh_h = int'(cfg_wdata);
                    2'd2: m_sh_b = int'(cfg_wdata);
                    default: m_en = int'(cfg_wdata[1:0]);
                endcase
            end
            if (errset) m_err = 1;
            else if (clr) m_err = 0;
        end
        m_gate  = (m_mode == 1) && (m_cyc - m_ws < longint'(m_h));
        e.gate  = m_gate;
        e.pulse = 2'(pulse_new);
        e.busy  = (m_mode != 0);
        e.done  = (m_mode == 2);
        e.err   = 1'(m_err);
        e.rd_v  = rd_req;
        case (cfg_addr)
            2'd0: e.rd = 16'(m_sh_p);
            2'd1: e.rd = 16'(m_sh_h);
            2'd2: e.rd = 16'(m_sh_b);
            default: e.rd = 16'(((m_done_cnt & 255) << 8) | (m_err << 3) |
                                ((m_mode != 0 ? 1 : 0) << 2) | m_en);
        endcase
        expq.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("gate_o", 32'(gate), 32'(e.gate));
            check("pulse_out_o", 32'(pulse_out), 32'(e.pulse));
            check("busy_o", 32'(busy), 32'(e.busy));
            check("done_o", 32'(done), 32'(e.done));
            check("err_o", 32'(err), 32'(e.err));
            if (e.rd_v) check("cfg_rdata_o", 32'(cfg_rdata), 32'(e.rd));
        end
    end

    initial begin
        pulse_in = 2'b11;
        forever begin
            @(negedge clk);
            #1;
            pulse_in = pulse_rand ? 2'($urandom_range(0, 3)) : 2'b11;
        end
    end

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        #1;
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        $display("WR addr=%0d data=0x%04h", a, d);
        @(negedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        @(negedge clk);
        #1;
        cfg_addr = a; rd_req = 1'b1;
        @(negedge clk);
        $display("RD addr=%0d data=0x%04h", a, cfg_rdata);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_within_budget", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gate"}, 32'(gate), 32'd0);
        check({tag, "_pulse"}, 32'(pulse_out), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'd0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        idle(3);
        #1 rst_n = 1'b1;
        rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);

        // Default 30/100 window, continuous
        wr(2'd3, 16'h0007);
        idle(230);
        rd(2'd3);
        wr(2'd3, 16'h000B);
        idle(3);

        // Three-window burst with done latency
        pulse_rand = 1'b1;
        wr(2'd0, 16'd10); wr(2'd1, 16'd4); wr(2'd2, 16'd3);
        wr(2'd3, 16'h0007);
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("done_latency", 32'(k), 32'd30);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        rd(2'd3);

        // Zero period error, clear, recovery
        wr(2'd0, 16'd0); wr(2'd2, 16'd2);
        wr(2'd3, 16'h0007);
        check("err_on_zero_period", 32'(err), 32'd1);
        wr(2'd3, 16'h0013);
        wr(2'd0, 16'd8);
        wr(2'd3, 16'h0007);
        wait_idle(100);

        // Mid-period PERIOD change takes effect at the boundary
        wr(2'd0, 16'd20); wr(2'd1, 16'd7); wr(2'd2, 16'd0);
        wr(2'd3, 16'h0007);
        idle(4);
        wr(2'd0, 16'd6);
        idle(50);
        wr(2'd3, 16'h000B);

        // 100% duty, channel 1 disabled
        wr(2'd0, 16'd10); wr(2'd1, 16'd50);
        wr(2'd3, 16'h0005);
        idle(40);
        wr(2'd3, 16'h0003);
        idle(10);
        wr(2'd1, 16'd0);
        idle(25);

        // STOP mid-window, START|STOP from idle, reset mid-run
        wr(2'd1, 16'd6);
        wr(2'd3, 16'h0007);
        idle(2);
        wr(2'd3, 16'h000B);
        idle(3);
        wr(2'd3, 16'h000F);
        idle(3);
        wr(2'd3, 16'h0007);
        idle(3);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("midrun_reset");
        idle(3);
        #1 rst_n = 1'b1;
        rd(2'd0);

        // Randomised register traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0: wr(2'd0, ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 12)));
                1: wr(2'd1, 16'($urandom_range(0, 14)));
                2: wr(2'd2, 16'($urandom_range(0, 4)));
                3, 4: wr(2'd3, 16'h0004 | 16'($urandom_range(0, 3)));
                5: wr(2'd3, 16'h0008 | 16'($urandom_range(0, 3)));
                6: wr(2'd3, 16'($urandom_range(0, 31)));
                7: rd(2'($urandom_range(0, 3)));
                default: idle(1);
            endcase
            idle($urandom_range(0, 25));
        end
        wr(2'd3, 16'h000B);
        wait_idle(50);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
